// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster-order pixel stream into 3x3 neighbourhood
// windows for the conv MAC array. Two line memories hold the previous two
// rows; a 3x3 shift register tracks the last three columns. Windows are only
// produced where the kernel lies fully inside the image (no padding).
module conv_window_gen #(
    parameter int IMAGE_WIDTH  = 220,
    parameter int IMAGE_HEIGHT = 220,
    parameter int KERNEL       = 3,
    parameter int DIN_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [DIN_WIDTH-1:0]     data_in,
    output logic [9*DIN_WIDTH-1:0]   window_out,
    output logic                     valid_out,
    output logic                     frame_done
);

    // The datapath below is hard-wired for a 3x3 kernel.
    generate
        if (KERNEL != 3) begin : g_bad_kernel
            $error("conv_window_gen: only KERNEL == 3 is supported");
        end
    endgenerate

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]                 col_r;
    logic [RW-1:0]                 row_r;
    logic [DIN_WIDTH-1:0]          line_a_r [IMAGE_WIDTH];
    logic [DIN_WIDTH-1:0]          line_b_r [IMAGE_WIDTH];
    logic [DIN_WIDTH-1:0]          top_s;
    logic [DIN_WIDTH-1:0]          mid_s;
    logic [8:0][DIN_WIDTH-1:0]     win_r;
    logic [8:0][DIN_WIDTH-1:0]     win_nxt_s;
    logic                          emit_s;
    logic                          last_s;

    // Read both line memories at the current column before this cycle's write lands.
    always_comb begin
        top_s = line_a_r[col_r];
        mid_s = line_b_r[col_r];
    end

    // Next window: shift columns left, new column {top, mid, bot} enters at j=2.
    always_comb begin
        win_nxt_s    = win_r;
        win_nxt_s[0] = win_r[1];
        win_nxt_s[1] = win_r[2];
        win_nxt_s[2] = top_s;
        win_nxt_s[3] = win_r[4];
        win_nxt_s[4] = win_r[5];
        win_nxt_s[5] = mid_s;
        win_nxt_s[6] = win_r[7];
        win_nxt_s[7] = win_r[8];
        win_nxt_s[8] = data_in;
    end

    // A window is complete only once two full rows and two columns precede the pixel;
    // this also masks stale line data at the start of a frame and across row wraps.
    always_comb begin
        emit_s = (row_r >= ROW_TWO) && (col_r >= COL_TWO);
        last_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
    end

    // Line memories: row r-1 moves into lineA, the incoming pixel into lineB (no reset, RAM-friendly).
    always_ff @(posedge clk) begin
        if (valid_in) begin
            line_a_r[col_r] <= mid_s;
            line_b_r[col_r] <= data_in;
        end
    end

    // Raster position counters; both wrap at the frame end so frames can run back to back.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r <= '0;
            row_r <= '0;
        end else if (valid_in) begin
            if (col_r == COL_LAST) begin
                col_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Shift register and registered outputs; window_out only loads for exposed windows.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_r      <= '0;
            window_out <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= valid_in && emit_s;
            frame_done <= valid_in && emit_s && last_s;
            if (valid_in) begin
                win_r <= win_nxt_s;
                if (emit_s) begin
                    window_out <= win_nxt_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a small 5x4x8 instance for directed scenarios and
// a default-parameter instance for a full random 220x220 frame. Expected windows
// are built from a full image copy held in the bench and queued on the scoreboard.
module tb_conv_window_gen;

    localparam int SW = 5;
    localparam int SH = 4;
    localparam int SD = 8;
    localparam int BW = 220;
    localparam int BH = 220;
    localparam int BD = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              s_valid;
    logic [SD-1:0]     s_data;
    logic [9*SD-1:0]   s_win;
    logic              s_vout;
    logic              s_fd;
    logic              b_valid;
    logic [BD-1:0]     b_data;
    logic [9*BD-1:0]   b_win;
    logic              b_vout;
    logic              b_fd;

    conv_window_gen #(.IMAGE_WIDTH(SW), .IMAGE_HEIGHT(SH), .KERNEL(3), .DIN_WIDTH(SD)) u_small (
        .clk(clk), .reset(reset), .valid_in(s_valid), .data_in(s_data),
        .window_out(s_win), .valid_out(s_vout), .frame_done(s_fd)
    );

    conv_window_gen u_big (
        .clk(clk), .reset(reset), .valid_in(b_valid), .data_in(b_data),
        .window_out(b_win), .valid_out(b_vout), .frame_done(b_fd)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [9*SD:0]   q_s [$];
    logic [9*BD:0]   q_b [$];
    logic [9*SD-1:0] got_s [$];
    int n_win_s = 0, n_fd_s = 0, n_win_b = 0, n_fd_b = 0;
    logic [SD-1:0] img_s [SW*SH];
    logic [BD-1:0] img_b [BW*BH];
    int sr = 0, sc = 0, br = 0, bc = 0;
    logic prev_rst = 1'b1, prev_sv = 1'b0, prev_bv = 1'b0;

    task automatic chk(input string tag, input logic [9*BD+1:0] obs, input logic [9*BD+1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*SD-1:0] mkwin(input int b0, input int b1, input int b2);
        logic [9*SD-1:0] w;
        int base [3];
        base = '{b0, b1, b2};
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*SD +: SD] = SD'(base[i] + j);
        return w;
    endfunction

    task automatic send_s(input logic [SD-1:0] d);
        logic [9*SD-1:0] w;
        logic emit, last;
        s_valid = 1'b1;
        s_data  = d;
        img_s[sr*SW+sc] = d;
        emit = (sr >= 2 && sc >= 2);
        last = (sr == SH-1 && sc == SW-1);
        if (emit) begin
            for (int k = 0; k < 9; k++) w[k*SD +: SD] = img_s[(sr-2+k/3)*SW + (sc-2+k%3)];
            q_s.push_back({last, w});
        end
        if (sc == SW-1) begin sc = 0; sr = (sr == SH-1) ? 0 : sr + 1; end
        else sc++;
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("s_latency", {s_vout, s_fd}, {emit, emit && last});
    endtask

    task automatic send_b(input logic [BD-1:0] d);
        logic [9*BD-1:0] w;
        logic emit, last;
        b_valid = 1'b1;
        b_data  = d;
        img_b[br*BW+bc] = d;
        emit = (br >= 2 && bc >= 2);
        last = (br == BH-1 && bc == BW-1);
        if (emit) begin
            for (int k = 0; k < 9; k++) w[k*BD +: BD] = img_b[(br-2+k/3)*BW + (bc-2+k%3)];
            q_b.push_back({last, w});
        end
        if (bc == BW-1) begin bc = 0; br = (br == BH-1) ? 0 : br + 1; end
        else bc++;
        @(posedge clk); #1;
        b_valid = 1'b0;
        chk("b_latency", {b_vout, b_fd}, {emit, emit && last});
    endtask

    // Scoreboard monitor: sample outputs mid-cycle and pop expected windows.
    always @(negedge clk) begin
        if (prev_rst) begin
            chk("rst_out_s", {s_vout, s_fd, s_win}, '0);
            chk("rst_out_b", {b_vout, b_fd, b_win}, '0);
        end else begin
            if (!prev_sv) chk("gap_s", {s_vout, s_fd}, '0);
            if (s_vout) begin
                chk("sb_s_nonempty", q_s.size() != 0, 1);
                if (q_s.size() != 0) chk("win_s", {s_fd, s_win}, q_s.pop_front());
                got_s.push_back(s_win);
                n_win_s++;
                if (s_fd) n_fd_s++;
            end else begin
                chk("fd_no_v_s", s_fd, 0);
            end
            if (!prev_bv) chk("gap_b", {b_vout, b_fd}, '0);
            if (b_vout) begin
                chk("sb_b_nonempty", q_b.size() != 0, 1);
                if (q_b.size() != 0) chk("win_b", {b_fd, b_win}, q_b.pop_front());
                n_win_b++;
                if (b_fd) n_fd_b++;
            end else begin
                chk("fd_no_v_b", b_fd, 0);
            end
        end
        prev_rst = reset;
        prev_sv  = s_valid;
        prev_bv  = b_valid;
    end

    initial begin
        int base_w, base_f;
        reset = 1'b1; s_valid = 1'b0; s_data = '0; b_valid = 1'b0; b_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset: everything stays zero for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_s", {s_vout, s_fd, s_win}, '0);
            chk("idle_b", {b_vout, b_fd, b_win}, '0);
        end
        @(posedge clk); #1;

        // Continuous ramp 0..19.
        got_s.delete(); base_w = n_win_s; base_f = n_fd_s;
        for (int d = 0; d < 20; d++) send_s(SD'(d));
        repeat (2) @(posedge clk); #1;
        chk("ramp_count", n_win_s - base_w, 6);
        chk("ramp_fd", n_fd_s - base_f, 1);
        chk("ramp_first", got_s[0], mkwin(0, 5, 10));
        chk("ramp_last", got_s[5], mkwin(7, 12, 17));

        // Same ramp with random idle gaps.
        got_s.delete(); base_w = n_win_s; base_f = n_fd_s;
        for (int d = 0; d < 20; d++) begin
            if ($urandom_range(1, 0) == 1) begin @(posedge clk); #1; end
            send_s(SD'(d));
        end
        repeat (2) @(posedge clk); #1;
        chk("gap_count", n_win_s - base_w, 6);
        chk("gap_fd", n_fd_s - base_f, 1);
        chk("gap_first", got_s[0], mkwin(0, 5, 10));
        chk("gap_last", got_s[5], mkwin(7, 12, 17));

        // Two back-to-back frames.
        got_s.delete(); base_w = n_win_s; base_f = n_fd_s;
        for (int d = 0; d < 20; d++) send_s(SD'(d));
        for (int d = 100; d < 120; d++) send_s(SD'(d));
        repeat (2) @(posedge clk); #1;
        chk("b2b_count", n_win_s - base_w, 12);
        chk("b2b_fd", n_fd_s - base_f, 2);
        chk("b2b_f2_first", got_s[6], mkwin(100, 105, 110));

        // Reset mid-frame, with a window-producing pixel arriving during reset.
        got_s.delete(); base_w = n_win_s;
        for (int d = 0; d < 13; d++) send_s(SD'(d));
        reset = 1'b1; s_valid = 1'b1; s_data = SD'(13);
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("rst_drop", {s_vout, s_fd, s_win}, '0);
        @(posedge clk); #1;
        reset = 1'b0; sr = 0; sc = 0; br = 0; bc = 0;
        chk("rst_pre_count", n_win_s - base_w, 1);
        for (int d = 0; d < 20; d++) send_s(SD'(d));
        repeat (2) @(posedge clk); #1;
        chk("rst_post_count", n_win_s - base_w, 7);
        chk("rst_post_first", got_s[1], mkwin(0, 5, 10));
        chk("rst_post_last", got_s[6], mkwin(7, 12, 17));

        // Full-size random frame on the default-parameter instance.
        base_w = n_win_b; base_f = n_fd_b;
        for (int p = 0; p < BW*BH; p++) send_b(BD'($urandom));
        repeat (2) @(posedge clk); #1;
        chk("big_count", n_win_b - base_w, 218*218);
        chk("big_fd", n_fd_b - base_f, 1);

        chk("sb_s_drained", q_s.size(), 0);
        chk("sb_b_drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
